// File: rtl/vga_pixel_stream_gen_pkg.sv
// Shared encodings and helpers for the VGA pixel stream engine.
package vga_stream_pkg;

  typedef enum logic [1:0] {
    MODE_FB    = 2'b00,
    MODE_BARS  = 2'b01,
    MODE_SOLID = 2'b10,
    MODE_BLANK = 2'b11
  } vga_mode_e;

  localparam int unsigned NUM_BARS = 8;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Channel enables {R,G,B} for colour bar idx: white, yellow, cyan, green,
  // magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb_on(input logic [2:0] idx);
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction

endpackage

// File: rtl/vga_pixel_stream_gen_sync_counter.sv
// Horizontal/vertical raster counters with active, sync and frame decode.
module vga_sync_counter
  import vga_stream_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned H_W     = $clog2(H_TOTAL),
  localparam int unsigned V_W     = $clog2(V_TOTAL)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic [H_W-1:0] h_cnt_o,
  output logic           active_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic           frame_first_o,
  output logic           line_end_o,
  output logic           frame_end_o
);

  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic           line_end, frame_end;

  // Raster position decode (active-high sync flags; polarity applied at the output).
  always_comb begin
    line_end      = (32'(h_cnt_q) == H_TOTAL - 1);
    frame_end     = line_end && (32'(v_cnt_q) == V_TOTAL - 1);
    active_o      = (32'(h_cnt_q) < H_ACTIVE) && (32'(v_cnt_q) < V_ACTIVE);
    hsync_o       = (32'(h_cnt_q) >= H_ACTIVE + H_FP) &&
                    (32'(h_cnt_q) <  H_ACTIVE + H_FP + H_SYNC);
    vsync_o       = (32'(v_cnt_q) >= V_ACTIVE + V_FP) &&
                    (32'(v_cnt_q) <  V_ACTIVE + V_FP + V_SYNC);
    frame_first_o = (h_cnt_q == '0) && (v_cnt_q == '0);
    line_end_o    = line_end;
    frame_end_o   = frame_end;
    h_cnt_o       = h_cnt_q;
  end

  // Counter next state: h wraps every line, v wraps every frame.
  always_comb begin
    h_cnt_d = h_cnt_q + H_W'(1);
    v_cnt_d = v_cnt_q;
    if (line_end) begin
      h_cnt_d = '0;
      v_cnt_d = frame_end ? '0 : v_cnt_q + V_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/vga_pixel_stream_gen.sv
// Pixel-clock VGA engine: raster timing, framebuffer read, pattern generation
// and a fixed-latency pipeline that keeps sync/de aligned with colour.
module vga_pixel_stream_gen
  import vga_stream_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 800,
  parameter int unsigned H_FP         = 40,
  parameter int unsigned H_SYNC       = 128,
  parameter int unsigned H_BP         = 88,
  parameter int unsigned V_ACTIVE     = 600,
  parameter int unsigned V_FP         = 1,
  parameter int unsigned V_SYNC       = 4,
  parameter int unsigned V_BP         = 23,
  parameter bit          H_POL        = 1'b0,
  parameter bit          V_POL        = 1'b0,
  parameter int unsigned RED_W        = 5,
  parameter int unsigned GREEN_W      = 6,
  parameter int unsigned BLUE_W       = 5,
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned RD_LATENCY   = 2,
  localparam int unsigned PIX_W       = RED_W + GREEN_W + BLUE_W,
  localparam int unsigned DATA_W      = PIX_PER_WORD * PIX_W
) (
  input  logic               pixclk,
  input  logic               reset_pixclk,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [PIX_W-1:0]   solid_color,
  output logic               fb_rd_en,
  output logic [ADDR_W-1:0]  fb_rd_addr,
  input  logic [DATA_W-1:0]  fb_rd_data,
  output logic [RED_W-1:0]   red_out,
  output logic [GREEN_W-1:0] green_out,
  output logic [BLUE_W-1:0]  blue_out,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned WORDS   = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
  localparam int unsigned BAR_W   = H_ACTIVE / NUM_BARS;
  localparam int unsigned BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned LANE_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  typedef struct packed {
    logic              de;
    logic              hs;
    logic              vs;
    logic              fs;
    logic              rd;
    logic              is_fb;
    logic [LANE_W-1:0] lane;
    logic [PIX_W-1:0]  pat;
  } stage_t;

  logic [H_W-1:0]    h_cnt;
  logic              active, hs_act, vs_act, frame_first, line_end, frame_end;
  vga_mode_e         mode_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BAR_CW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic [LANE_W-1:0] lane;
  logic              fb_strobe;
  logic [2:0]        bar_on;
  stage_t            cur;
  stage_t            dly_q [RD_LATENCY];
  stage_t            last;
  logic [DATA_W-1:0] word_q, word_d;
  logic [PIX_W-1:0]  pix_fb, pix;
  logic [RED_W-1:0]  red_q;
  logic [GREEN_W-1:0] green_q;
  logic [BLUE_W-1:0] blue_q;
  logic              hsync_q, vsync_q, de_q, fs_q;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .clk_i         (pixclk),
    .rst_i         (reset_pixclk),
    .h_cnt_o       (h_cnt),
    .active_o      (active),
    .hsync_o       (hs_act),
    .vsync_o       (vs_act),
    .frame_first_o (frame_first),
    .line_end_o    (line_end),
    .frame_end_o   (frame_end)
  );

  // Counter-stage decode: read strobe and the record entering the delay line.
  always_comb begin
    lane      = LANE_W'(32'(h_cnt) % PIX_PER_WORD);
    fb_strobe = active && (mode_q == MODE_FB) && (lane == '0);
    bar_on    = bar_rgb_on(bar_idx_q);
    cur       = '0;
    cur.de    = active;
    cur.hs    = hs_act;
    cur.vs    = vs_act;
    cur.fs    = frame_first;
    cur.rd    = fb_strobe;
    cur.is_fb = (mode_q == MODE_FB);
    cur.lane  = lane;
    case (mode_q)
      MODE_BARS:  cur.pat = {{RED_W{bar_on[2]}}, {GREEN_W{bar_on[1]}}, {BLUE_W{bar_on[0]}}};
      MODE_SOLID: cur.pat = solid_color;
      default:    cur.pat = '0;
    endcase
  end

  // Reset gates the strobe so no read is issued while the raster is held.
  assign fb_rd_en   = fb_strobe & ~reset_pixclk;
  assign fb_rd_addr = addr_q;

  // Mode only changes on the last pixel of a frame.
  always_ff @(posedge pixclk) begin
    if (reset_pixclk) begin
      mode_q <= MODE_FB;
    end else if (frame_end) begin
      mode_q <= vga_mode_e'(mode);
    end
  end

  // Next read address and colour-bar position.
  always_comb begin
    addr_d = addr_q;
    if (frame_end) begin
      addr_d = '0;
    end else if (fb_strobe) begin
      addr_d = (32'(addr_q) == WORDS - 1) ? '0 : addr_q + ADDR_W'(1);
    end
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (line_end) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end else if (active) begin
      if (32'(bar_cnt_q) == BAR_W - 1) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BAR_CW'(1);
      end
    end
  end

  // Address and bar-counter registers.
  always_ff @(posedge pixclk) begin
    if (reset_pixclk) begin
      addr_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      addr_q    <= addr_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Delay line matching the framebuffer read latency.
  always_ff @(posedge pixclk) begin
    if (reset_pixclk) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= cur;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Output stage: hold the word across its lanes, select the lane, blank.
  // Data is only valid in the cycle matching its strobe, so later lanes of
  // the same word come from word_q.
  always_comb begin
    last   = dly_q[RD_LATENCY-1];
    word_d = last.rd ? fb_rd_data : word_q;
    pix_fb = '0;
    for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
      if (last.lane == LANE_W'(k)) begin
        pix_fb = word_d[k*PIX_W +: PIX_W];
      end
    end
    pix = last.is_fb ? pix_fb : last.pat;
    if (!last.de || !enable) begin
      pix = '0;
    end
  end

  // Output registers.
  always_ff @(posedge pixclk) begin
    if (reset_pixclk) begin
      word_q  <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      word_q  <= word_d;
      red_q   <= pix[PIX_W-1 -: RED_W];
      green_q <= pix[BLUE_W +: GREEN_W];
      blue_q  <= pix[BLUE_W-1:0];
      hsync_q <= last.hs ? H_POL : ~H_POL;
      vsync_q <= last.vs ? V_POL : ~V_POL;
      de_q    <= last.de;
      fs_q    <= last.fs;
    end
  end

  assign red_out     = red_q;
  assign green_out   = green_q;
  assign blue_out    = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pixel_stream_gen.sv
// Directed bench for vga_pixel_stream_gen using a 16x8 raster
// (H_TOTAL 24, V_TOTAL 12, frame 288 cycles, read latency 2).
module tb_vga_pixel_stream_gen;

  localparam int HT    = 24;
  localparam int FRAME = 288;
  localparam int PIPE  = 3;

  logic        clk = 1'b0;
  logic        reset_pixclk = 1'b1;
  logic        enable = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [15:0] solid_color = 16'h0000;
  logic        fb_rd_en;
  logic [7:0]  fb_rd_addr;
  logic [31:0] fb_rd_data;
  logic [4:0]  red_out;
  logic [5:0]  green_out;
  logic [4:0]  blue_out;
  logic        hsync, vsync, de, frame_start;

  always #5 clk = ~clk;

  vga_pixel_stream_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0),
    .RED_W(5), .GREEN_W(6), .BLUE_W(5),
    .PIX_PER_WORD(2), .ADDR_W(8), .RD_LATENCY(2)
  ) dut (
    .pixclk(clk), .reset_pixclk(reset_pixclk), .enable(enable), .mode(mode),
    .solid_color(solid_color), .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data), .red_out(red_out), .green_out(green_out),
    .blue_out(blue_out), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start)
  );

  // Latency-2 memory: low lane = address, high lane = its complement.
  logic       p1_v = 1'b0, p2_v = 1'b0;
  logic [7:0] p1_a = '0, p2_a = '0;
  always @(posedge clk) begin
    p1_v <= fb_rd_en;
    p1_a <= fb_rd_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign fb_rd_data = p2_v ? {~{8'h00, p2_a}, {8'h00, p2_a}} : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_release(input logic [1:0] m, input logic en, input logic [15:0] sol);
    @(negedge clk);
    mode = m; enable = en; solid_color = sol; reset_pixclk = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_pixclk = 1'b0;
    cyc = 0;
  endtask

  // After n edges from release the outputs show raster position n-PIPE.
  task automatic advance_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  function automatic int unsigned outs();
    return {12'h0, red_out, green_out, blue_out, de, hsync, vsync, frame_start};
  endfunction

  typedef struct {
    logic [1:0]  m;
    logic        en;
    logic [15:0] sol;
    int          h;
    int          v;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic        de, hs, vs, fs;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  initial begin
    int k;
    int de_cnt, hs_cnt, vs_cnt, rd_cnt, seq_err, first_hs, first_vs, prev_a, max_a;
    int unsigned exp;

    // Frame 1 samples: mode, enable, solid, h, v -> r, g, b, de, hs, vs, fs
    tbl[0]  = '{2'b01, 1'b1, 16'h0000,  0,  0, 5'd31, 6'd63, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2'b01, 1'b1, 16'h0000,  1,  3, 5'd31, 6'd63, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{2'b01, 1'b1, 16'h0000,  2,  3, 5'd31, 6'd63, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{2'b01, 1'b1, 16'h0000,  5,  3, 5'd0,  6'd63, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{2'b01, 1'b1, 16'h0000,  7,  3, 5'd0,  6'd63, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{2'b01, 1'b1, 16'h0000,  9,  3, 5'd31, 6'd0,  5'd31, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{2'b01, 1'b1, 16'h0000, 11,  3, 5'd31, 6'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{2'b01, 1'b1, 16'h0000, 13,  3, 5'd0,  6'd0,  5'd31, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{2'b01, 1'b1, 16'h0000, 15,  3, 5'd0,  6'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{2'b01, 1'b1, 16'h0000, 16,  0, 5'd0,  6'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{2'b01, 1'b1, 16'h0000, 18,  1, 5'd0,  6'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{2'b01, 1'b1, 16'h0000, 20,  1, 5'd0,  6'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{2'b01, 1'b1, 16'h0000, 21,  1, 5'd0,  6'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{2'b10, 1'b1, 16'hF800,  4,  2, 5'd31, 6'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{2'b10, 1'b1, 16'h07E0,  7,  7, 5'd0,  6'd63, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{2'b11, 1'b1, 16'hFFFF,  3,  3, 5'd0,  6'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{2'b01, 1'b0, 16'h0000,  0,  0, 5'd0,  6'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1};
    tbl[17] = '{2'b10, 1'b0, 16'hFFFF, 19,  2, 5'd0,  6'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[18] = '{2'b10, 1'b1, 16'hFFFF,  0,  8, 5'd0,  6'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{2'b10, 1'b1, 16'hFFFF,  0,  9, 5'd0,  6'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{2'b10, 1'b1, 16'hFFFF,  5, 10, 5'd0,  6'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{2'b10, 1'b1, 16'hFFFF,  5, 11, 5'd0,  6'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[22] = '{2'b00, 1'b1, 16'h0000,  1,  0, 5'd31, 6'd63, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[23] = '{2'b00, 1'b1, 16'h0000,  4,  3, 5'd0,  6'd0,  5'd26, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[24] = '{2'b00, 1'b1, 16'h0000,  5,  3, 5'd31, 6'd63, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[25] = '{2'b00, 1'b1, 16'h0000, 15,  7, 5'd31, 6'd62, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0};
    tbl[26] = '{2'b00, 1'b1, 16'h0000, 14,  7, 5'd0,  6'd1,  5'd31, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[27] = '{2'b00, 1'b1, 16'h0000,  8,  5, 5'd0,  6'd1,  5'd12, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[28] = '{2'b00, 1'b1, 16'h0000,  0,  0, 5'd0,  6'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_colour", {red_out, green_out, blue_out}, 0);
    check("rst_de_fs", {de, frame_start}, 0);
    check("rst_syncs", {hsync, vsync}, 2'b11);
    check("rst_rd_en", fb_rd_en, 0);
    check("rst_addr", fb_rd_addr, 0);
    reset_pixclk = 1'b0;
    cyc = 0;

    // First frame_start latency after release.
    k = 0;
    while (k < 50 && !frame_start) begin
      @(posedge clk); @(negedge clk); cyc++; k++;
    end
    check("first_fs_latency", k, PIPE);

    // Frame period.
    k = 0;
    do begin
      @(posedge clk); @(negedge clk); cyc++; k++;
    end while (k < 1000 && !frame_start);
    check("fs_period", k, FRAME);

    // One full frame of timing and read-strobe statistics.
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; rd_cnt = 0; seq_err = 0;
    first_hs = -1; first_vs = -1; prev_a = -1; max_a = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (de) de_cnt++;
      if (!hsync) begin hs_cnt++; if (first_hs < 0) first_hs = i; end
      if (!vsync) begin vs_cnt++; if (first_vs < 0) first_vs = i; end
      if (fb_rd_en) begin
        rd_cnt++;
        if (prev_a >= 0 && int'(fb_rd_addr) != (prev_a + 1) % 64) seq_err++;
        prev_a = int'(fb_rd_addr);
        if (int'(fb_rd_addr) > max_a) max_a = int'(fb_rd_addr);
      end
      @(posedge clk); @(negedge clk); cyc++;
    end
    check("de_per_frame", de_cnt, 128);
    check("hsync_low_per_frame", hs_cnt, 36);
    check("vsync_low_per_frame", vs_cnt, 48);
    check("first_hsync_offset", first_hs, 18);
    check("first_vsync_offset", first_vs, 216);
    check("strobes_per_frame", rd_cnt, 64);
    check("addr_sequence_errors", seq_err, 0);
    check("addr_max", max_a, 63);

    // Mode change mid-frame takes effect only at the next frame.
    do_release(2'b00, 1'b1, 16'h0000);
    advance_to(FRAME + 4 * HT);
    mode = 2'b10; solid_color = 16'hF800;
    advance_to(FRAME + 6 * HT + 4 + PIPE);
    check("modechg_fb_mid", outs(), {5'd0, 6'd1, 5'd18, 4'b1110});
    advance_to(FRAME + 7 * HT + 15 + PIPE);
    check("modechg_fb_last", outs(), {5'd31, 6'd62, 5'd0, 4'b1110});
    advance_to(2 * FRAME + PIPE);
    check("modechg_solid_first", outs(), {5'd31, 6'd0, 5'd0, 4'b1111});
    advance_to(2 * FRAME + PIPE + 1);
    check("modechg_no_strobe", fb_rd_en, 0);

    // Reset in the middle of a line restarts the raster at (0,0).
    do_release(2'b00, 1'b1, 16'h0000);
    advance_to(FRAME + 2 * HT + 10 + PIPE);
    reset_pixclk = 1'b1;
    @(posedge clk); @(negedge clk);
    reset_pixclk = 1'b0;
    cyc = 0;
    check("midrst_outputs", outs(), {5'd0, 6'd0, 5'd0, 4'b0110});
    check("midrst_addr", fb_rd_addr, 0);
    k = 0;
    while (k < 50 && !frame_start) begin
      @(posedge clk); @(negedge clk); cyc++; k++;
    end
    check("midrst_fs_latency", k, PIPE);
    @(posedge clk); @(negedge clk); cyc++;
    check("midrst_pixel1", outs(), {5'd31, 6'd63, 5'd31, 4'b1110});

    // Table-driven pixel/timing vectors.
    for (int i = 0; i < NV; i++) begin
      do_release(tbl[i].m, tbl[i].en, tbl[i].sol);
      advance_to(FRAME + tbl[i].v * HT + tbl[i].h + PIPE);
      exp = {12'h0, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs};
      check($sformatf("vec%0d_h%0d_v%0d", i, tbl[i].h, tbl[i].v), outs(), exp);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
